// File: rtl/tri_fu_bthmul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
package tri_fu_bthmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Booth digit field: {b[2i+1], b[2i], b[2i-1]}
    localparam int unsigned DIGIT_W = 3;

    // Number of Booth digits for a WIDTH-bit operand extended to WIDTH+2 bits
    function automatic int unsigned calc_nd(input int unsigned width);
        return (width + 3) / 2;
    endfunction

    // Number of BUSY retirement cycles when dpc digits are retired per cycle
    function automatic int unsigned calc_ni(input int unsigned width, input int unsigned dpc);
        return (calc_nd(width) + dpc - 1) / dpc;
    endfunction

endpackage

// File: rtl/tri_fu_bthmul_pp.sv
// Radix-4 Booth partial-product generator for one digit.
module tri_fu_bthmul_pp
    import tri_fu_bthmul_pkg::*;
#(
    parameter int unsigned AW = 36
) (
    input  logic [DIGIT_W-1:0] bits,
    input  logic [AW-1:0]      a,
    output logic [AW-1:0]      pp
);

    logic          neg;
    logic          x1;
    logic          x2;
    logic [AW-1:0] mag;

    // Decode the digit and form the two's-complement partial product
    always_comb begin
        neg = bits[2];
        x1  = bits[1] ^ bits[0];
        x2  = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
        if (x2) begin
            mag = a << 1;
        end else if (x1) begin
            mag = a;
        end else begin
            mag = '0;
        end
        // Pattern 111 gives mag=0, so the negation below still yields 0
        pp = neg ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/tri_fu_bthmul_seq.sv
// Iterative radix-4 Booth multiplier retiring DPC digits per cycle.
module tri_fu_bthmul_seq
    import tri_fu_bthmul_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DPC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned AW = 2 * WIDTH + 4;
    localparam int unsigned NI = calc_ni(WIDTH, DPC);
    localparam int unsigned CW = $clog2(NI + 1);
    localparam int unsigned SH = 2 * DPC;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [AW-1:0]      a_q;
    logic [XW-1:0]      b_q;
    logic               b_prev_q;
    logic               ext_q;
    logic [AW-1:0]      acc_q;
    logic [2*WIDTH-1:0] out_p_q;
    logic               out_valid_q;
    logic               in_ready_q;

    logic [DPC-1:0][DIGIT_W-1:0] digit;
    logic [DPC-1:0][AW-1:0]      pp;
    logic [AW-1:0]               acc_step;
    logic [AW-1:0]               a_ext;
    logic [XW-1:0]               b_ext;
    logic                        b_sign;

    // One partial-product generator per digit retired this cycle
    for (genvar k = 0; k < DPC; k++) begin : g_digit
        if (k == 0) begin : g_lo
            assign digit[k] = {b_q[1], b_q[0], b_prev_q};
        end else begin : g_hi
            assign digit[k] = {b_q[2*k+1], b_q[2*k], b_q[2*k-1]};
        end
        tri_fu_bthmul_pp #(
            .AW (AW)
        ) u_pp (
            .bits (digit[k]),
            .a    (a_q),
            .pp   (pp[k])
        );
    end

    // Accumulate this cycle's weighted partial products; arithmetic wraps at AW bits
    always_comb begin
        acc_step = acc_q;
        for (int k = 0; k < int'(DPC); k++) begin
            acc_step = acc_step + (pp[k] << (2 * k));
        end
    end

    // Operand extension according to the requested signedness
    always_comb begin
        b_sign = in_signed & in_b[WIDTH-1];
        a_ext  = in_signed ? {{(AW - WIDTH){in_a[WIDTH-1]}}, in_a}
                           : {{(AW - WIDTH){1'b0}}, in_a};
        b_ext  = {{2{b_sign}}, in_b};
    end

    // Control FSM, shift registers, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            b_prev_q    <= 1'b0;
            ext_q       <= 1'b0;
            acc_q       <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_ext;
                        b_q        <= b_ext;
                        b_prev_q   <= 1'b0;
                        ext_q      <= b_sign;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // After NI retirement cycles the accumulator holds the product
                    if (cnt_q == CW'(NI)) begin
                        out_p_q     <= acc_q[2*WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        acc_q    <= acc_step;
                        b_prev_q <= b_q[SH-1];
                        b_q      <= {{SH{ext_q}}, b_q[XW-1:SH]};
                        a_q      <= a_q << SH;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;

endmodule
